// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, index/word types and the write-qualify helper.
// Latency: n/a (types only). Backpressure: n/a.
package pipeline_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = '0;

  // A write only counts when enabled and aimed at something other than $0.
  function automatic logic wr_live(input logic we, input reg_idx_t idx);
    return we && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index decode, $0 forcing, optional write-through (REGFILE_BYPASS_EN).
// Latency: zero cycles, rd_idx -> rd_dat. Backpressure: none; always presents data.
module regfile_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_dat,
  input  logic [ADDR_W-1:0]               rd_idx,
  input  logic                            byp_vld,
  input  logic [ADDR_W-1:0]               wr_idx,
  input  logic [DATA_W-1:0]               wr_dat,
  output logic [DATA_W-1:0]               rd_dat
);

  logic rd_is_zero;
  assign rd_is_zero = (rd_idx == '0);

`ifdef REGFILE_BYPASS_EN
  logic byp_hit;
  // byp_vld already excludes writes to $0 and writes during reset.
  assign byp_hit = byp_vld && (wr_idx == rd_idx);

  always_comb begin
    rd_dat = regs_dat[rd_idx];
    if (rd_is_zero) begin
      rd_dat = '0;
    end else if (byp_hit) begin
      rd_dat = wr_dat;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_vld, wr_idx, wr_dat};

  always_comb begin
    rd_dat = regs_dat[rd_idx];
    if (rd_is_zero) begin
      rd_dat = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// 32x32 MIPS register file: $0 hardwired to zero, two combinational reads, one clocked write.
// Latency: reads zero cycles; writes visible next cycle (same cycle with REGFILE_BYPASS_EN). Backpressure: none.
module register_file #(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int NUM_REGS = pipeline_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  import pipeline_pkg::*;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic                            wr_vld;
  logic                            byp_vld;

  assign wr_vld = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));
  // Never bypass while held in reset so every index reads 0 there.
  assign byp_vld = wr_vld && !rst;

  always_comb begin
    regs_d = regs_q;
    if (wr_vld) begin
      regs_d[WriteReg] = wb_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rd_port1 (
    .regs_dat(regs_q),
    .rd_idx  (ReadReg1),
    .byp_vld (byp_vld),
    .wr_idx  (WriteReg),
    .wr_dat  (wb_data),
    .rd_dat  (ReadData1)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rd_port2 (
    .regs_dat(regs_q),
    .rd_idx  (ReadReg2),
    .byp_vld (byp_vld),
    .wr_idx  (WriteReg),
    .wr_dat  (wb_data),
    .rd_dat  (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Randomised + directed bench for register_file with a scoreboard queue and an array reference model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] wb_data;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .wb_data  (wb_data),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents.
  logic [31:0] model [32];

  logic [31:0] exp1_q [$];
  logic [31:0] exp2_q [$];
  string       name_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic r,
                                             input logic we, input logic [4:0] wi,
                                             input logic [31:0] wd);
    if (r || idx == 5'd0) return 32'h0;
    if (BYP && we && wi != 5'd0 && wi == idx) return wd;
    return model[idx];
  endfunction

  // Drive one cycle of inputs just after a rising edge, queue the expected
  // reads, then let the edge land and update the model.
  task automatic step(input logic r, input logic we, input logic [4:0] wi,
                      input logic [31:0] wd, input logic [4:0] r1,
                      input logic [4:0] r2, input string nm);
    #1;
    rst = r; RegWrite = we; WriteReg = wi; wb_data = wd;
    ReadReg1 = r1; ReadReg2 = r2;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end
    exp1_q.push_back(model_read(r1, r, we, wi, wd));
    exp2_q.push_back(model_read(r2, r, we, wi, wd));
    name_q.push_back(nm);
    @(posedge clk);
    if (!rst && we && wi != 5'd0) model[wi] = wd;
  endtask

  // Monitor: outputs are always presented, sample mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp1_q.size() > 0) begin
        logic [31:0] e1, e2;
        string nm;
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (ReadData1 !== e1) begin
          n_fail++;
          $display("FAIL %s ReadData1 (idx %0d): got %h expected %h", nm, ReadReg1, ReadData1, e1);
        end
        n_checks++;
        if (ReadData2 !== e2) begin
          n_fail++;
          $display("FAIL %s ReadData2 (idx %0d): got %h expected %h", nm, ReadReg2, ReadData2, e2);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; RegWrite = 1'b0; WriteReg = '0; wb_data = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    @(posedge clk);

    step(1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd0, "reset_hold");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31, "release");

    // Reset mid-run wipes $5 without waiting for an edge.
    step(1'b0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd5, "wr5");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
    step(1'b1, 1'b1, 5'd5, 32'hFFFF, 5'd5, 5'd5, "rst_mid");
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 5'(i), 32'hA5A5_A5A5, 5'(i), 5'(i + 16), "post_rst_all");

    // Basic write/read.
    step(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd9, "wr8");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, "rd8_both");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8, "rd9");

    // $0 protection.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr0_same");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "wr0_after");

    // Same-cycle write/read hazard.
    step(1'b0, 1'b1, 5'd3, 32'h11, 5'd1, 5'd2, "wr3_a");
    step(1'b0, 1'b1, 5'd3, 32'h22, 5'd0, 5'd3, "hazard3");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "hazard3_after");

    // Write-enable gating.
    step(1'b0, 1'b1, 5'd4, 32'h5555, 5'd4, 5'd0, "wr4");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd4, 32'hAAAA, 5'd4, 5'd4, "we_gate");

    // Back-to-back writes.
    step(1'b0, 1'b1, 5'd31, 32'h1, 5'd31, 5'd1, "b2b_a");
    step(1'b0, 1'b1, 5'd31, 32'h2, 5'd31, 5'd1, "b2b_b");
    step(1'b0, 1'b1, 5'd1,  32'h3, 5'd31, 5'd1, "b2b_c");
    step(1'b0, 1'b0, 5'd0,  32'h0, 5'd31, 5'd1, "b2b_rd");
    step(1'b0, 1'b0, 5'd0,  32'h0, 5'd4, 5'd8, "b2b_others");

    // Random traffic with deliberate read/write collisions and occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic        r, we;
      logic [4:0]  wi, r1, r2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 3) != 0);
      wi = 5'($urandom_range(0, 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 2) == 0) ? wi : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wi : 5'($urandom_range(0, 31));
      step(r, we, wi, wd, r1, r2, "random");
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && exp1_q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp1_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
